// File: rtl/mp_addsub_seq_pkg.sv
// Shared types and elaboration-time helpers for the multi-precision
// adder-subtractor sequencer.
package mp_addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t;

  function automatic int ctr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Chunk width must be 16 or a larger power of four.
  function automatic bit m_is_legal(input int m);
    int r;
    r = m;
    if (m < 16) return 1'b0;
    while (r > 1) begin
      if ((r % 4) != 0) return 1'b0;
      r = r / 4;
    end
    return 1'b1;
  endfunction

  function automatic bit params_legal(input int m, input int n);
    return m_is_legal(m) && (n >= 1);
  endfunction

endpackage

// File: rtl/mp_addsub_seq_cla.sv
// M-bit carry-lookahead adder-subtractor built from 4-bit lookahead groups,
// with group generate/propagate chained across the word.
module claAddSub16Pow4 #(
  parameter int M = 16
) (
  input  logic         sub,
  input  logic         cin,
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  output logic [M-1:0] out,
  output logic         cout,
  output logic         v,
  output logic         g,
  output logic         p
);

  localparam int NG = M / 4;

  logic [M-1:0] yy;
  logic [M-1:0] gen;
  logic [M-1:0] prop;
  logic [M:0]   c;
  logic         g_all;
  logic         p_all;

  always_comb begin
    yy    = y ^ {M{sub}};
    gen   = x & yy;
    prop  = x ^ yy;
    c     = '0;
    c[0]  = cin | sub;
    g_all = 1'b0;
    p_all = 1'b1;
    for (int j = 0; j < NG; j++) begin
      automatic int b = 4 * j;
      automatic logic gg;
      automatic logic pg;
      c[b+1] = gen[b] | (prop[b] & c[b]);
      c[b+2] = gen[b+1] | (prop[b+1] & gen[b]) | (prop[b+1] & prop[b] & c[b]);
      c[b+3] = gen[b+2] | (prop[b+2] & gen[b+1]) | (prop[b+2] & prop[b+1] & gen[b])
             | (prop[b+2] & prop[b+1] & prop[b] & c[b]);
      gg = gen[b+3] | (prop[b+3] & gen[b+2]) | (prop[b+3] & prop[b+2] & gen[b+1])
         | (prop[b+3] & prop[b+2] & prop[b+1] & gen[b]);
      pg = &prop[b +: 4];
      c[b+4] = gg | (pg & c[b]);
      g_all  = gg | (pg & g_all);
      p_all  = p_all & pg;
    end
    out  = prop ^ c[M-1:0];
    cout = c[M];
    v    = c[M] ^ c[M-1];
    g    = g_all;
    p    = p_all;
  end

endmodule

// File: rtl/mp_addsub_seq.sv
// Sequences a W = M*N bit add/subtract through one M-bit CLA, one chunk per
// clock, least-significant chunk first, chaining the carry in a register.
module mp_addsub_seq
  import mp_addsub_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           sub,
  input  logic [M*N-1:0] x,
  input  logic [M*N-1:0] y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M*N-1:0] out,
  output logic           cout,
  output logic           v,
  output logic           z
);

  localparam int W  = M * N;
  localparam int CW = ctr_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!params_legal(M, N)) begin : g_bad_params
    $error("mp_addsub_seq: M must be 16 or a higher power of 4 and N >= 1");
  end

  mp_state_t     state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic          sub_q, sub_d;
  logic [W-1:0]  xreg_q, xreg_d;
  logic [W-1:0]  yreg_q, yreg_d;
  logic [W-1:0]  out_q, out_d;
  logic          cout_q, cout_d;
  logic          v_q, v_d;
  logic          z_q, z_d;

  logic [M-1:0]  xa;
  logic [M-1:0]  ya;
  logic [M-1:0]  sum_c;
  logic          cout_c;
  logic          v_c;

  // Subtraction inverts y here so the adder only ever sees an add with cin.
  assign xa = xreg_q[M-1:0];
  assign ya = yreg_q[M-1:0] ^ {M{sub_q}};

  claAddSub16Pow4 #(.M(M)) u_cla (
    .sub  (1'b0),
    .cin  (carry_q),
    .x    (xa),
    .y    (ya),
    .out  (sum_c),
    .cout (cout_c),
    .v    (v_c),
    .g    (),
    .p    ()
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    xreg_d  = xreg_q;
    yreg_d  = yreg_q;
    out_d   = out_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          xreg_d  = x;
          yreg_d  = y;
          sub_d   = sub;
          carry_d = sub;
          k_d     = '0;
          out_d   = '0;
          cout_d  = 1'b0;
          v_d     = 1'b0;
          z_d     = 1'b0;
        end
      end
      RUN: begin
        out_d[M*int'(k_q) +: M] = sum_c;
        carry_d = cout_c;
        xreg_d  = xreg_q >> M;
        yreg_d  = yreg_q >> M;
        k_d     = k_q + 1'b1;
        // Only the top chunk's carry and overflow describe the full word.
        if (k_q == LAST) begin
          state_d = DONE;
          k_d     = '0;
          cout_d  = cout_c;
          v_d     = v_c;
          z_d     = (out_d == '0);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      xreg_q  <= '0;
      yreg_q  <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      xreg_q  <= xreg_d;
      yreg_q  <= yreg_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign cout      = cout_q;
  assign v         = v_q;
  assign z         = z_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Randomized and directed checks of mp_addsub_seq (M=16, N=4) against a
// whole-word arithmetic reference model.
module tb_mp_addsub_seq;

  localparam int M = 16;
  localparam int N = 4;
  localparam int W = M * N;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         cout;
  logic         v;
  logic         z;

  int checks;
  int errors;

  mp_addsub_seq #(.M(M), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .v         (v),
    .z         (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] out;
    logic         cout;
    logic         v;
    logic         z;
  } result_t;

  // Whole-word reference: two's-complement add of x and (possibly inverted) y.
  function automatic result_t refModel(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    result_t      r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + (W+1)'(s);
    r.out  = full[W-1:0];
    r.cout = full[W];
    r.v    = (a[W-1] == bb[W-1]) && (r.out[W-1] != a[W-1]);
    r.z    = (r.out == '0);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input result_t e);
    checkOutput({tag, ".out"},  out, e.out);
    checkOutput({tag, ".cout"}, W'(cout), W'(e.cout));
    checkOutput({tag, ".v"},    W'(v), W'(e.v));
    checkOutput({tag, ".z"},    W'(z), W'(e.z));
    checkOutput({tag, ".valid"}, W'(out_valid), W'(1));
  endtask

  // Offers one operand, waits for its result, optionally stalls, then takes it.
  task automatic applyStimulus(input string tag, input logic s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int stall);
    result_t e;
    int      waitCnt;
    int      lat;
    e = refModel(s, a, b);
    @(negedge clk);
    sub = s; x = a; y = b; in_valid = 1'b1;
    waitCnt = 0;
    while (!in_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput({tag, ".acceptReady"}, W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    checkOutput({tag, ".runOut"}, out, '0);
    checkOutput({tag, ".runReady"}, W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, W'(lat), W'(N));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
    end
    checkResult(tag, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, ".postValid"}, W'(out_valid), W'(0));
    checkOutput({tag, ".postReady"}, W'(in_ready), W'(1));
  endtask

  result_t      eA;
  result_t      eB;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  int           lat;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sub = 1'b0;
    x = '0;
    y = '0;
    #1;
    checkOutput("reset.ready", W'(in_ready), W'(1));
    checkOutput("reset.valid", W'(out_valid), W'(0));
    checkOutput("reset.out", out, '0);
    checkOutput("reset.flags", W'({cout, v, z}), W'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("addWrap",  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
    applyStimulus("subBorrow", 1'b1, 64'h0, 64'h1, 0);
    applyStimulus("addOvf",   1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0);
    applyStimulus("subOvf",   1'b1, 64'h8000_0000_0000_0000, 64'h1, 0);
    applyStimulus("chain",    1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 0);
    applyStimulus("chain0",   1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1);
    applyStimulus("chain1",   1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 2);
    applyStimulus("subEq",    1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0);

    // Backpressure: result held while a new operand waits, then taken in turn.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    eA = refModel(1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444);
    eB = refModel(1'b1, ra, rb);
    @(negedge clk);
    sub = 1'b0; x = 64'h0123_4567_89AB_CDEF; y = 64'h1111_2222_3333_4444; in_valid = 1'b1;
    @(posedge clk);
    #1;
    sub = 1'b1; x = ra; y = rb;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp.latency", W'(lat), W'(N));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkResult("bp.hold", eA);
      checkOutput("bp.inReady", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp.idleReady", W'(in_ready), W'(1));
    checkOutput("bp.idleValid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("bp.pendingTaken", W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp.pendLatency", W'(lat), W'(N));
    checkResult("bp.pending", eB);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset two RUN edges into an operation.
    @(negedge clk);
    sub = 1'b0; x = 64'hFFFF_FFFF_FFFF_FFFF; y = 64'hFFFF_FFFF_FFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstRun.valid", W'(out_valid), W'(0));
    checkOutput("rstRun.out", out, '0);
    checkOutput("rstRun.ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("afterRst", 1'b0, 64'h5, 64'h3, 0);

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), ra, rb,
                    int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
- Multi-precision two's-complement adder-subtractor sequencer for W = M*N-bit operands.
- Processes one M-bit chunk per clock, least-significant first, through a single CLA adder-subtractor datapath, and chains the carry between chunks in a register.
- Sits directly upstream of the CLA datapath: it feeds chunk operands and carry, and consumes the chunk sum, cout and v.
- Valid/ready handshakes on the operand and result interfaces.

Parameters:
- M, 16, chunk width; must be 16 or a higher power of 4.
- N, 4, number of chunks; N >= 1; total width W = M*N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand; high only in IDLE.
- sub  input  1  0 = x+y, 1 = x-y; sampled on accept.
- x  input  W  operand A; sampled on accept.
- y  input  W  operand B; sampled on accept.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- out  output  W  result x+y or x-y, modulo 2^W.
- cout  output  1  raw carry out of bit W-1; for subtract, 1 = no borrow.
- v  output  1  signed overflow of the full W-bit operation.
- z  output  1  out == 0.

Behaviour:
- Reset (async, any state): state=IDLE, chunk counter k=0, carry register=0, operand registers=0, out=0, cout=0, v=0, z=0, out_valid=0, in_ready=1 immediately.
- States:
  - IDLE --(in_valid & in_ready)--> RUN.
  - RUN --(k==N-1 at edge)--> DONE.
  - DONE --(out_valid & out_ready)--> IDLE.
- Accept edge:
  - Capture x, y and sub into registers; k=0; carry register=sub.
  - Clear out/cout/v/z to 0; they stay 0 until DONE.
- RUN, each edge:
  - Datapath sees chunk k: xa = xreg[M-1:0], ya = yreg[M-1:0] ^ {M{subreg}}, cin = carry register.
  - The adder's own sub input is tied 0, so inversion happens in this block.
  - Capture sum chunk into result bits [M*k+M-1 : M*k]; carry register <= chunk cout.
  - Shift xreg/yreg right by M. k increments.
- Final RUN edge (k==N-1):
  - cout <= chunk cout; v <= chunk v.
  - z <= (assembled result == 0).
  - out_valid=1 next cycle.
- Latency: out_valid rises exactly N rising edges after the accept edge. Throughput is one operation per N+2 cycles minimum: accept, N RUN cycles, one DONE transfer.
- N=1: a single RUN cycle; carry register seeds cin with sub only.
- DONE:
  - out, cout, v and z are held stable while out_ready=0, for any number of cycles.
  - in_ready=0. in_valid is ignored; no operand is dropped and none is captured.
- Transfer edge: return to IDLE. in_ready=1 the following cycle. No same-cycle result-out/operand-in overlap.
- in_valid during RUN: ignored (in_ready=0).
- Reset mid-RUN or mid-DONE: the operation is abandoned with no partial result. All outputs take their reset values.
- Arithmetic:
  - Result is x + (y ^ {W{sub}}) + sub, mod 2^W.
  - v = carry into MSB XOR carry out of MSB, taken from the top chunk.
  - Lower-chunk overflow indications are discarded.
- Counter width: max(1, $clog2(N)).

Decomposition:
- Package mp_addsub_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t.
  - Localparam function for counter width.
  - Parameter-legality check (M is 16 or a higher power of 4, N >= 1).
- One sub-module: a single instance of the existing CLA adder-subtractor claAddSub16Pow4 with M=M.
  - Connections: sub=0, cin=carry register, x=xa, y=ya.
  - out, cout and v are consumed; g and p are left unconnected.
- All registers and the FSM live in mp_addsub_seq.

Test Plan (M=16, N=4, W=64):
- Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> out=0, cout=1, v=0, z=1; out_valid exactly 4 edges after accept.
- Sub 0x0 - 0x1 -> out=0xFFFF_FFFF_FFFF_FFFF, cout=0 (borrow), v=0, z=0.
- Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> out=0x8000_0000_0000_0000, v=1, cout=0. Sub 0x8000_0000_0000_0000 - 0x1 -> out=0x7FFF_FFFF_FFFF_FFFF, v=1, cout=1.
- Inter-chunk carry: add 0x0000_FFFF_FFFF_FFFF + 0x1 -> 0x0001_0000_0000_0000, cout=0, v=0. Check that every chunk boundary propagates.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 and a new operand -> outputs stable, in_ready=0, new operand not taken. On out_ready=1: transfer, IDLE, then the pending operand is accepted next cycle and its result is correct.
- Reset asserted asynchronously mid-RUN (k=2) -> out_valid=0, out=0, in_ready=1 before the next edge. A following add of 0x5 + 0x3 gives 0x8 with no residue from the aborted operation.
